// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures the high/low run lengths of wclk (/2) and
// rclk (/3) in the master clk domain, tracks lock per channel and keeps a
// sticky error flag per channel for the status register bank.

// One channel of the monitor: run-length measurement, lock FSM, sticky error.
module clk_div_monitor_chan #(
  parameter int CW        = 4,
  parameter int HI        = 1,
  parameter int LO        = 1,
  parameter int LOCK_RUNS = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x_in,
  input  logic          en,
  input  logic          err_clr,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] hi_len,
  output logic [CW-1:0] lo_len
);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

  localparam logic [CW-1:0] RUN_MAX   = '1;
  localparam logic [CW-1:0] HI_LEN    = CW'(HI);
  localparam logic [CW-1:0] LO_LEN    = CW'(LO);
  localparam logic [CW-1:0] LOCK_N    = CW'(LOCK_RUNS);
  localparam logic [CW:0]   TIMEOUT_W = (CW+1)'(TIMEOUT);

  state_t        state, state_next;
  logic [CW-1:0] run, g, g_next, g_inc;
  logic          prev, chg, match, timeout, capture, err_set;

  assign chg     = x_in ^ prev;
  assign match   = prev ? (run == HI_LEN) : (run == LO_LEN);
  assign timeout = !chg && (({1'b0, run} + (CW+1)'(1)) == TIMEOUT_W);
  assign capture = en && chg && (state != ACQ);
  assign g_inc   = g + 1'b1;

  // Previous sample of the divided clock, kept running even while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= x_in;
  end

  // Length of the current level, restarting at 1 on every level change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= CW'(1);
    end else if (en) begin
      if (chg)                 run <= CW'(1);
      else if (run != RUN_MAX) run <= run + 1'b1;
    end
  end

  // Publish the just-completed run length once the channel is past acquisition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_len <= '0;
      lo_len <= '0;
    end else if (capture) begin
      if (prev) hi_len <= run;
      else      lo_len <= run;
    end
  end

  // Lock FSM next-state: qualify completed runs, detect stuck clock
  always_comb begin
    state_next = state;
    g_next     = g;
    err_set    = 1'b0;
    if (!en) begin
      state_next = ACQ;
      g_next     = '0;
    end else begin
      case (state)
        ACQ: begin
          if (chg) begin
            state_next = TRACK;
            g_next     = '0;
          end
        end
        TRACK: begin
          if (timeout) begin
            err_set    = 1'b1;
            g_next     = '0;
            state_next = ACQ;
          end else if (chg) begin
            if (match) begin
              g_next = g_inc;
              if (g_inc == LOCK_N) state_next = LOCKED;
            end else begin
              err_set = 1'b1;
              g_next  = '0;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            err_set    = 1'b1;
            g_next     = '0;
            state_next = ACQ;
          end else if (chg && !match) begin
            err_set    = 1'b1;
            g_next     = '0;
            state_next = TRACK;
          end
        end
        default: begin
          state_next = ACQ;
          g_next     = '0;
        end
      endcase
    end
  end

  // Lock FSM registers; locked is registered so it mirrors the LOCKED state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ACQ;
      g      <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      g      <= g_next;
      locked <= (state_next == LOCKED);
    end
  end

  // Sticky error: a new error in the clear cycle wins over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// Top level: two independent channel monitors sharing clock, reset and clear.
module clk_div_monitor #(
  parameter int CW        = 4,
  parameter int W_HI      = 1,
  parameter int W_LO      = 1,
  parameter int R_HI      = 1,
  parameter int R_LO      = 2,
  parameter int LOCK_RUNS = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wclk_in,
  input  logic          rclk_in,
  input  logic          w_en,
  input  logic          r_en,
  input  logic          err_clr,
  output logic          w_locked,
  output logic          r_locked,
  output logic          w_err,
  output logic          r_err,
  output logic [CW-1:0] w_hi_len,
  output logic [CW-1:0] w_lo_len,
  output logic [CW-1:0] r_hi_len,
  output logic [CW-1:0] r_lo_len
);

  clk_div_monitor_chan #(
    .CW(CW), .HI(W_HI), .LO(W_LO), .LOCK_RUNS(LOCK_RUNS), .TIMEOUT(TIMEOUT)
  ) u_wchan (
    .clk(clk), .rst(rst), .x_in(wclk_in), .en(w_en), .err_clr(err_clr),
    .locked(w_locked), .err(w_err), .hi_len(w_hi_len), .lo_len(w_lo_len)
  );

  clk_div_monitor_chan #(
    .CW(CW), .HI(R_HI), .LO(R_LO), .LOCK_RUNS(LOCK_RUNS), .TIMEOUT(TIMEOUT)
  ) u_rchan (
    .clk(clk), .rst(rst), .x_in(rclk_in), .en(r_en), .err_clr(err_clr),
    .locked(r_locked), .err(r_err), .hi_len(r_hi_len), .lo_len(r_lo_len)
  );

endmodule
